// File: rtl/fpnew_result_reorder.sv
// Reorder buffer restoring issue order for FPU results that complete out of order; optional
// same-cycle head bypass when FPNEW_REORDER_BYPASS_EN is defined.
module fpnew_result_reorder #(
    parameter int unsigned Width      = 32,
    parameter int unsigned NumEntries = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic                              alloc_valid_i,
    output logic                              alloc_ready_o,
    output logic [$clog2(NumEntries)-1:0]     alloc_id_o,
    input  logic                              res_valid_i,
    output logic                              res_ready_o,
    input  logic [$clog2(NumEntries)-1:0]     res_id_i,
    input  logic [Width-1:0]                  res_result_i,
    input  logic [4:0]                        res_status_i,
    input  logic                              res_ext_bit_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [Width-1:0]                  out_result_o,
    output logic [4:0]                        out_status_o,
    output logic                              out_ext_bit_o,
    output logic                              busy_o,
    output logic                              protocol_err_o
);
    localparam int unsigned IdWidth = $clog2(NumEntries);
    localparam logic [IdWidth:0] CntOne  = 1;
    localparam logic [IdWidth:0] CntFull = NumEntries[IdWidth:0];

    logic [NumEntries-1:0] alloc_q, done_q, ext_q;
    logic [Width-1:0]      result_q [NumEntries];
    logic [4:0]            status_q [NumEntries];
    logic [IdWidth:0]      rd_ptr_q, wr_ptr_q, count_q;
    logic                  err_q;

    logic [IdWidth-1:0] head, wr_idx;
    logic alloc_hs, res_ok, res_wr, res_bad, head_vld, retire, set_done, bypass;

    assign head   = rd_ptr_q[IdWidth-1:0];
    assign wr_idx = wr_ptr_q[IdWidth-1:0];

    assign alloc_ready_o  = (count_q != CntFull);
    assign alloc_id_o     = wr_idx;
    assign res_ready_o    = 1'b1;
    assign busy_o         = (count_q != '0);
    assign protocol_err_o = err_q;

    // Validity is judged on current state, so a result aimed at the slot being allocated this cycle is an error.
    assign alloc_hs = alloc_valid_i && alloc_ready_o && !flush_i;
    assign res_ok   = alloc_q[res_id_i] && !done_q[res_id_i];
    assign res_wr   = res_valid_i && res_ok && !flush_i;
    assign res_bad  = res_valid_i && !res_ok && !flush_i;
    assign head_vld = alloc_q[head] && done_q[head];

`ifdef FPNEW_REORDER_BYPASS_EN
    assign bypass = res_wr && (res_id_i == head);
    always_comb begin
        out_valid_o   = head_vld;
        out_result_o  = result_q[head];
        out_status_o  = status_q[head];
        out_ext_bit_o = ext_q[head];
        if (bypass) begin
            out_valid_o   = 1'b1;
            out_result_o  = res_result_i;
            out_status_o  = res_status_i;
            out_ext_bit_o = res_ext_bit_i;
        end
    end
`else
    assign bypass        = 1'b0;
    assign out_valid_o   = head_vld;
    assign out_result_o  = result_q[head];
    assign out_status_o  = status_q[head];
    assign out_ext_bit_o = ext_q[head];
`endif

    assign retire   = out_valid_o && out_ready_i && !flush_i;
    // A bypassed result that retires immediately never needs its done bit.
    assign set_done = res_wr && !(bypass && out_ready_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alloc_q  <= '0;
            done_q   <= '0;
            ext_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < NumEntries; i++) begin
                result_q[i] <= '0;
                status_q[i] <= '0;
            end
        end else if (flush_i) begin
            alloc_q  <= '0;
            done_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (res_bad) begin
                err_q <= 1'b1;
            end
            if (res_wr) begin
                result_q[res_id_i] <= res_result_i;
                status_q[res_id_i] <= res_status_i;
                ext_q[res_id_i]    <= res_ext_bit_i;
            end
            if (set_done) begin
                done_q[res_id_i] <= 1'b1;
            end
            if (retire) begin
                alloc_q[head] <= 1'b0;
                done_q[head]  <= 1'b0;
                rd_ptr_q      <= rd_ptr_q + CntOne;
            end
            // Alloc slot never equals the retiring slot: that would require a full buffer.
            if (alloc_hs) begin
                alloc_q[wr_idx] <= 1'b1;
                done_q[wr_idx]  <= 1'b0;
                wr_ptr_q        <= wr_ptr_q + CntOne;
            end
            case ({alloc_hs, retire})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_fpnew_result_reorder.sv
// Directed bench for fpnew_result_reorder with an issue-order scoreboard queue.
module tb_fpnew_result_reorder;
    typedef struct packed {
        logic [31:0] r;
        logic [4:0]  s;
        logic        e;
    } pay_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [1:0]  alloc_id;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [1:0]  res_id = '0;
    logic [31:0] res_result = '0;
    logic [4:0]  res_status = '0;
    logic        res_ext = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_status;
    logic        out_ext;
    logic        busy;
    logic        perr;

    int   tests = 0;
    int   fails = 0;
    pay_t sb[$];
    pay_t pend[4];
    pay_t e;

    fpnew_result_reorder #(.Width(32), .NumEntries(4)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_id_o(alloc_id),
        .res_valid_i(res_valid), .res_ready_o(res_ready), .res_id_i(res_id),
        .res_result_i(res_result), .res_status_i(res_status), .res_ext_bit_i(res_ext),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_result_o(out_result),
        .out_status_o(out_status), .out_ext_bit_o(out_ext),
        .busy_o(busy), .protocol_err_o(perr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [31:0] v, input logic [4:0] s, input logic x, input logic [1:0] exp_id);
        chk("alloc_rdy", alloc_ready, 1);
        chk("alloc_id", alloc_id, exp_id);
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        pend[exp_id] = '{r: v, s: s, e: x};
        sb.push_back(pend[exp_id]);
    endtask

    task automatic do_res(input logic [1:0] id);
        res_valid  = 1'b1;
        res_id     = id;
        res_result = pend[id].r;
        res_status = pend[id].s;
        res_ext    = pend[id].e;
        tick();
        res_valid  = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
    endtask

    task automatic pop_out(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, out_valid, 1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_res"}, out_result, e.r);
            chk({tag, "_st"}, out_status, e.s);
            chk({tag, "_ext"}, out_ext, e.e);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #12 rst = 1'b0;
        tick();
        // reset state
        chk("rst_alloc_rdy", alloc_ready, 1);
        chk("rst_alloc_id", alloc_id, 0);
        chk("rst_out_vld", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_perr", perr, 0);
        chk("rst_out_res", out_result, 0);
        chk("rst_res_rdy", res_ready, 1);

        // single op: output one cycle after result write
        do_alloc(32'h3F80_0000, 5'd0, 1'b0, 2'd0);
        chk("single_busy", busy, 1);
        do_res(2'd0);
        chk("single_vld_n1", out_valid, 1);
        pop_out("single");
        chk("single_busy_end", busy, 0);

        // out of order completion
        do_flush();
        do_alloc(32'hA, 5'd1, 1'b0, 2'd0);
        do_alloc(32'hB, 5'd2, 1'b1, 2'd1);
        do_alloc(32'hC, 5'd4, 1'b0, 2'd2);
        do_res(2'd2);
        chk("ooo_hold", out_valid, 0);
        tick();
        chk("ooo_hold2", out_valid, 0);
        do_res(2'd0);
        do_res(2'd1);
        pop_out("ooo_a");
        pop_out("ooo_b");
        pop_out("ooo_c");
        chk("ooo_empty", out_valid, 0);

        // full, refused alloc during retire, wrap
        do_flush();
        for (int i = 0; i < 4; i++) do_alloc(32'h100 + i, 5'(i), i[0], 2'(i));
        chk("full_rdy", alloc_ready, 0);
        do_res(2'd0);
        chk("full_head_vld", out_valid, 1);
        e = sb.pop_front();
        chk("full_head_res", out_result, e.r);
        out_ready = 1'b1;
        alloc_valid = 1'b1;
        tick();
        out_ready = 1'b0;
        alloc_valid = 1'b0;
        chk("full_refused_busy", busy, 1);
        do_alloc(32'h200, 5'd0, 1'b1, 2'd0);
        for (int i = 0; i < 20; i++) begin
            do_res(2'(i + 1));
            pop_out("steady");
            do_alloc(32'h300 + i, 5'(i), i[1], 2'(i + 1));
        end
        for (int i = 0; i < 4; i++) begin
            do_res(2'(i + 1));
            pop_out("drain");
        end
        chk("steady_sb_empty", sb.size(), 0);
        chk("steady_busy", busy, 0);

        // backpressure: stable output for 5 cycles
        do_flush();
        do_alloc(32'hDEAD_BEEF, 5'h13, 1'b1, 2'd0);
        do_res(2'd0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", out_valid, 1);
            chk("bp_res", out_result, 32'hDEAD_BEEF);
            chk("bp_st", out_status, 5'h13);
            tick();
        end
        pop_out("bp");
        chk("bp_after", out_valid, 0);

        // protocol errors
        do_flush();
        chk("err_clear", perr, 0);
        res_valid = 1'b1; res_id = 2'd3; res_result = 32'h77;
        tick();
        res_valid = 1'b0;
        chk("err_unalloc", perr, 1);
        chk("err_unalloc_vld", out_valid, 0);
        do_alloc(32'h1234, 5'd2, 1'b0, 2'd0);
        do_res(2'd0);
        res_valid = 1'b1; res_id = 2'd0; res_result = 32'h5555; res_status = 5'd9;
        tick();
        res_valid = 1'b0;
        pop_out("dup_keep");

        // flush mid-operation, then a late result
        do_alloc(32'h1, 5'd0, 1'b0, 2'd1);
        do_alloc(32'h2, 5'd0, 1'b0, 2'd2);
        do_alloc(32'h3, 5'd0, 1'b0, 2'd3);
        do_res(2'd2);
        do_flush();
        chk("fl_busy", busy, 0);
        chk("fl_id", alloc_id, 0);
        chk("fl_perr", perr, 0);
        chk("fl_vld", out_valid, 0);
        res_valid = 1'b1; res_id = 2'd1; res_result = 32'h9;
        tick();
        res_valid = 1'b0;
        chk("fl_late_err", perr, 1);

        // asynchronous reset mid-operation
        do_flush();
        do_alloc(32'h42, 5'd0, 1'b0, 2'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_id", alloc_id, 0);
        #2 rst = 1'b0;
        tick();
        res_valid = 1'b1; res_id = 2'd0; res_result = 32'h42;
        tick();
        res_valid = 1'b0;
        chk("arst_late_err", perr, 1);
        chk("arst_vld", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
